// File: rtl/music_tone_decoder.sv
// Speaker tone decoder: times half-periods of an incoming square wave, normalises them to
// the base octave, looks them up in the note table and reports confirmed note codes.
module music_tone_decoder #(
    parameter int unsigned CNT_W    = 18,
    parameter int unsigned TOL      = 2,
    parameter int unsigned STABLE_N = 3,
    parameter int unsigned TIMEOUT  = 140000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       speaker_in,
    output logic [7:0] fullnote,
    output logic [2:0] octave,
    output logic [3:0] note,
    output logic       note_valid,
    output logic       note_strobe,
    output logic       silence,
    output logic       err_range
);
    localparam int unsigned K_W  = $clog2(CNT_W + 1);
    localparam int unsigned ST_W = $clog2(STABLE_N + 1);
    localparam logic [CNT_W-1:0] NORM_LIM = CNT_W'(512 + TOL);
    localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(271 - TOL);
    localparam logic [CNT_W-1:0] TOL_V    = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TMO_V    = CNT_W'(TIMEOUT);
    localparam logic [ST_W-1:0]  STAB_V   = ST_W'(STABLE_N);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_MATCH} state_t;

    function automatic logic [9:0] half_ref(input logic [3:0] idx);
        case (idx)
            4'd0:    half_ref = 10'd512;
            4'd1:    half_ref = 10'd483;
            4'd2:    half_ref = 10'd456;
            4'd3:    half_ref = 10'd431;
            4'd4:    half_ref = 10'd406;
            4'd5:    half_ref = 10'd384;
            4'd6:    half_ref = 10'd362;
            4'd7:    half_ref = 10'd342;
            4'd8:    half_ref = 10'd323;
            4'd9:    half_ref = 10'd304;
            4'd10:   half_ref = 10'd287;
            4'd11:   half_ref = 10'd271;
            default: half_ref = 10'd0;
        endcase
    endfunction

    logic             sync1_q, sync2_q, sync3_q;
    logic [1:0]       prime_q;
    logic             edge_w;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q;
    logic             timeout_w;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [3:0]       idx_q, idx_d;
    logic             start_w, norm_done_w, norm_bad_w, last_idx_w, hit_w, drop_w;
    logic [CNT_W-1:0] ref_w;
    logic             dec_err_w, dec_hit_w;
    logic [6:0]       cand_w;

    logic [ST_W-1:0]  stable_q, stable_d;
    logic [6:0]       cand_q;
    logic             confirm_q;

    logic [7:0]       fullnote_q;
    logic [2:0]       octave_q;
    logic [3:0]       note_q;
    logic             note_valid_q, note_strobe_q, silence_q, err_range_q;

    // Edges are ignored until the synchroniser has refilled after reset, so a pin
    // already high at reset release is not mistaken for a transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            prime_q <= '0;
        end else begin
            sync1_q <= speaker_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
        end
    end

    assign edge_w    = (prime_q == 2'd3) && (sync2_q ^ sync3_q);
    assign timeout_w = !edge_w && (cnt_q == TMO_V);

    always_comb begin
        cnt_d = cnt_q;
        if (edge_w)            cnt_d = CNT_W'(1);
        else if (cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (edge_w)         armed_q <= 1'b1;
            else if (timeout_w) armed_q <= 1'b0;
        end
    end

    assign start_w     = edge_w && armed_q && (state_q == S_IDLE);
    assign drop_w      = edge_w && (state_q != S_IDLE);
    assign norm_done_w = (v_q <= NORM_LIM);
    assign norm_bad_w  = (k_q < K_W'(3)) || (k_q > K_W'(8)) || (v_q < MIN_V);
    assign last_idx_w  = (idx_q == 4'd11);
    assign ref_w       = CNT_W'(half_ref(idx_q));
    assign hit_w       = ((v_q + TOL_V) >= ref_w) && (v_q <= (ref_w + TOL_V));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            v_q     <= '0;
            k_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        k_d     = k_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start_w) begin
                    v_d     = cnt_q;
                    k_d     = '0;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (!norm_done_w) begin
                    v_d = v_q >> 1;
                    k_d = k_q + K_W'(1);
                end else if (norm_bad_w) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = '0;
                    state_d = S_MATCH;
                end
            end
            S_MATCH: begin
                if (hit_w || last_idx_w) state_d = S_IDLE;
                else                     idx_d   = idx_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dec_err_w = 1'b0;
        dec_hit_w = 1'b0;
        case (state_q)
            S_NORM:  dec_err_w = norm_done_w && norm_bad_w;
            S_MATCH: begin
                dec_hit_w = hit_w;
                dec_err_w = !hit_w && last_idx_w;
            end
            default: ;
        endcase
        cand_w = {3'(K_W'(8) - k_q), idx_q};
    end

    always_comb begin
        stable_d = stable_q;
        if (timeout_w || dec_err_w || drop_w) begin
            stable_d = '0;
        end else if (dec_hit_w) begin
            if (cand_w != cand_q)       stable_d = ST_W'(1);
            else if (stable_q != STAB_V) stable_d = stable_q + ST_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q  <= '0;
            cand_q    <= '0;
            confirm_q <= 1'b0;
        end else begin
            stable_q  <= stable_d;
            if (dec_hit_w) cand_q <= cand_w;
            confirm_q <= dec_hit_w && (stable_d == STAB_V);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fullnote_q    <= '0;
            octave_q      <= '0;
            note_q        <= '0;
            note_valid_q  <= 1'b0;
            note_strobe_q <= 1'b0;
            silence_q     <= 1'b1;
            err_range_q   <= 1'b0;
        end else begin
            note_strobe_q <= 1'b0;
            err_range_q   <= dec_err_w;
            if (timeout_w) begin
                silence_q    <= 1'b1;
                note_valid_q <= 1'b0;
                fullnote_q   <= '0;
                octave_q     <= '0;
                note_q       <= '0;
            end else if (confirm_q) begin
                octave_q      <= cand_q[6:4];
                note_q        <= cand_q[3:0];
                fullnote_q    <= {2'b00, cand_q[6:4], 3'b000} + {3'b000, cand_q[6:4], 2'b00}
                               + {4'b0000, cand_q[3:0]};
                note_valid_q  <= 1'b1;
                silence_q     <= 1'b0;
                note_strobe_q <= !note_valid_q || (cand_q != {octave_q, note_q});
            end
        end
    end

    assign fullnote    = fullnote_q;
    assign octave      = octave_q;
    assign note        = note_q;
    assign note_valid  = note_valid_q;
    assign note_strobe = note_strobe_q;
    assign silence     = silence_q;
    assign err_range   = err_range_q;
endmodule
